// File: rtl/serial_tx_shifter.sv
// Framed parallel-in / serial-out transmitter: start bit (0), WIDTH data bits
// in caller-selected order, stop bit (1), each bit held for DIV clock cycles.
module serial_tx_shifter #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    input  logic             msb_first,
    output logic             load_ready,
    output logic             sout,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = ($clog2(WIDTH + 1) > 0) ? $clog2(WIDTH + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             r_msb;
    logic             w_msb_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BIT_W-1:0] w_bit_nxt;

    logic             r_sout;
    logic             r_frame;
    logic             r_busy;
    logic             r_done;
    logic             w_sout_nxt;
    logic             w_frame_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic             w_period_end;
    logic             w_accept;

    assign w_period_end = (r_div_cnt == DIV_LAST);

    // Ready in the last STOP cycle lets the next frame start with no idle gap.
    assign load_ready = (r_state == S_IDLE) || ((r_state == S_STOP) && w_period_end);
    assign w_accept   = load_valid && load_ready;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_msb_nxt   = r_msb;
        w_div_nxt   = r_div_cnt;
        w_bit_nxt   = r_bit_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = din;
                    w_msb_nxt   = msb_first;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            S_START: begin
                if (w_period_end) begin
                    w_state_nxt = S_DATA;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_period_end) begin
                    w_div_nxt   = '0;
                    w_shift_nxt = r_msb ? (r_shift << 1) : (r_shift >> 1);
                    w_bit_nxt   = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_period_end) begin
                    w_div_nxt = '0;
                    w_bit_nxt = '0;
                    if (w_accept) begin
                        w_state_nxt = S_START;
                        w_shift_nxt = din;
                        w_msb_nxt   = msb_first;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_div_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from next-state values and then registered, so they
    // change on the same edge as the state and never glitch.
    always_comb begin
        w_sout_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_sout_nxt = 1'b0;
            S_DATA:  w_sout_nxt = w_msb_nxt ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];
            default: w_sout_nxt = 1'b1;
        endcase
        w_frame_nxt = (w_state_nxt == S_DATA);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_STOP) && (w_div_nxt == DIV_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_msb     <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_sout    <= 1'b1;
            r_frame   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_msb     <= w_msb_nxt;
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_sout    <= w_sout_nxt;
            r_frame   <= w_frame_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign sout  = r_sout;
    assign frame = r_frame;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed bench for serial_tx_shifter: a WIDTH=4/DIV=4 instance for framing,
// ordering, back-to-back and reset cases, plus a WIDTH=8/DIV=1 instance.
module tb_serial_tx_shifter;

    logic       clk;
    logic       rst_n;

    logic [3:0] din;
    logic       load_valid;
    logic       msb_first;
    logic       load_ready;
    logic       sout;
    logic       frame;
    logic       busy;
    logic       done;

    logic [7:0] b_din;
    logic       b_load_valid;
    logic       b_msb_first;
    logic       b_load_ready;
    logic       b_sout;
    logic       b_frame;
    logic       b_busy;
    logic       b_done;

    int         errors;
    int         checks;

    serial_tx_shifter #(.WIDTH(4), .DIV(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .load_valid (load_valid),
        .msb_first  (msb_first),
        .load_ready (load_ready),
        .sout       (sout),
        .frame      (frame),
        .busy       (busy),
        .done       (done)
    );

    serial_tx_shifter #(.WIDTH(8), .DIV(1)) u_dut_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (b_din),
        .load_valid (b_load_valid),
        .msb_first  (b_msb_first),
        .load_ready (b_load_ready),
        .sout       (b_sout),
        .frame      (b_frame),
        .busy       (b_busy),
        .done       (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, " sout"},       sout,       1'b1);
        chk({name, " busy"},       busy,       1'b0);
        chk({name, " frame"},      frame,      1'b0);
        chk({name, " done"},       done,       1'b0);
        chk({name, " load_ready"}, load_ready, 1'b1);
    endtask

    // Presents one word for a single cycle; returns #1 after the accepting edge.
    task automatic accept(input logic [3:0] d, input logic m);
        din        = d;
        msb_first  = m;
        load_valid = 1'b1;
        step();
    endtask

    // Called #1 after the accepting edge; checks frame cycles 1..24 and returns
    // while cycle 24 (final STOP cycle) is still on the outputs.
    // exp[5] is the first line value (start bit), exp[0] the stop bit.
    task automatic run_frame(input string name, input logic [5:0] exp,
                             input logic [3:0] din_after, input logic valid_after);
        din        = din_after;
        load_valid = valid_after;
        for (int c = 1; c <= 24; c++) begin
            chk($sformatf("%s c%0d sout", name, c),  sout,       exp[5 - (c - 1) / 4]);
            chk($sformatf("%s c%0d frame", name, c), frame,      (c >= 5) && (c <= 20));
            chk($sformatf("%s c%0d done", name, c),  done,       c == 24);
            chk($sformatf("%s c%0d busy", name, c),  busy,       1'b1);
            chk($sformatf("%s c%0d ready", name, c), load_ready, c == 24);
            if (c < 24) step();
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b1;
        din          = '0;
        load_valid   = 1'b0;
        msb_first    = 1'b0;
        b_din        = '0;
        b_load_valid = 1'b0;
        b_msb_first  = 1'b0;

        // Reset asserted before any clock edge: outputs must already be idle.
        #1 rst_n = 1'b0;
        #2;
        chk_idle("reset");
        chk("reset fast sout", b_sout, 1'b1);
        chk("reset fast busy", b_busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            chk_idle($sformatf("idle%0d", i));
        end

        // LSB-first 1011: line 0,1,1,0,1,1.
        accept(4'b1011, 1'b0);
        run_frame("lsb", 6'b011011, 4'b1011, 1'b0);
        step();
        chk_idle("lsb end");

        // MSB-first 1011: line 0,1,0,1,1,1; din cleared after acceptance.
        accept(4'b1011, 1'b1);
        run_frame("msb", 6'b010111, 4'b0000, 1'b0);
        step();
        chk_idle("msb end");

        // Back-to-back: valid stays high through frame 1 with din=5; only the
        // final STOP cycle accepts it. A=1010 LSB -> 0,0,1,0,1,1; 5 -> 0,1,0,1,0,1.
        accept(4'hA, 1'b0);
        run_frame("b2b_a", 6'b001011, 4'h5, 1'b1);
        step();
        run_frame("b2b_b", 6'b010101, 4'h5, 1'b0);
        step();
        chk_idle("b2b end");

        // Reset during the second data bit (cycle 10) of an all-zero word.
        accept(4'b0000, 1'b0);
        load_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("rst_mid pre sout",  sout,  1'b0);
        chk("rst_mid pre frame", frame, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid sout",  sout,       1'b1);
        chk("rst_mid busy",  busy,       1'b0);
        chk("rst_mid frame", frame,      1'b0);
        chk("rst_mid ready", load_ready, 1'b1);
        #1 rst_n = 1'b1;
        step();
        chk_idle("rst_mid idle");

        // After reset: MSB-first 0110 -> 0,0,1,1,0,1.
        accept(4'b0110, 1'b1);
        run_frame("post_rst", 6'b001101, 4'b0110, 1'b0);
        step();
        chk_idle("post_rst end");

        // WIDTH=8, DIV=1: C3 LSB-first -> 0,1,1,0,0,0,0,1,1,1 on cycles 1..10.
        begin
            logic [9:0] fast_exp;
            fast_exp     = 10'b0110000111;
            b_din        = 8'hC3;
            b_msb_first  = 1'b0;
            b_load_valid = 1'b1;
            step();
            b_load_valid = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                chk($sformatf("fast c%0d sout", c),  b_sout,  fast_exp[10 - c]);
                chk($sformatf("fast c%0d frame", c), b_frame, (c >= 2) && (c <= 9));
                chk($sformatf("fast c%0d done", c),  b_done,  c == 10);
                chk($sformatf("fast c%0d busy", c),  b_busy,  1'b1);
                if (c < 10) step();
            end
            step();
            chk("fast end sout",  b_sout,       1'b1);
            chk("fast end busy",  b_busy,       1'b0);
            chk("fast end done",  b_done,       1'b0);
            chk("fast end ready", b_load_ready, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
- Parallel-in, serial-out framed transmitter; the transmit end of the serial link our universal shift register receives on.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per bit period.
- Frame format is start bit (0), WIDTH data bits in selectable order, then stop bit (1).
- Drives the serial line that feeds a downstream shift register's serial input.

Parameters:
WIDTH, 4, data word width in bits (>=1)
DIV, 4, clock cycles per serial bit period (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  WIDTH  parallel word to transmit
load_valid  input  1  din/msb_first valid this cycle
msb_first  input  1  1 = shift out din[WIDTH-1] first (left shift), 0 = din[0] first (right shift)
load_ready  output  1  block can accept a word this cycle
sout  output  1  serial line, idles high
frame  output  1  high while a data bit (not start/stop) is on sout
busy  output  1  high from acceptance cycle+1 until the frame ends
done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, sout=1, frame=0, busy=0, done=0, load_ready=1. Shift register, bit counter and divider counter clear. A frame in progress is abandoned; sout returns high immediately, not at the next edge.
- FSM states: IDLE, START, DATA, STOP.
- Divider counter runs 0..DIV-1 in START/DATA/STOP. A bit period ends when the counter reaches DIV-1.
- Acceptance: load_valid && load_ready at a rising edge. din and msb_first are captured into internal registers, and FSM goes to START. Changes on din/msb_first after acceptance have no effect.
- load_ready is 1 in IDLE and in the final cycle of STOP; it is 0 otherwise. load_valid while load_ready=0 is ignored and is not queued.
- IDLE: sout=1, busy=0.
- START: sout=0 for DIV cycles, then DATA.
- DATA: WIDTH bit periods; frame=1.
  - sout = shift register bit 0 when LSB-first, or bit WIDTH-1 when MSB-first.
  - At the end of each bit period the register shifts toward the output bit and the bit counter increments.
  - After WIDTH periods, go to STOP.
- STOP: sout=1 for DIV cycles; done=1 in the last cycle only.
  - Next state is START if a word is accepted in that cycle (back-to-back, no idle gap); otherwise IDLE.
- Latency: sout falls on the first edge after acceptance. A full frame occupies exactly (WIDTH+2)*DIV cycles.
- busy=1 in START, DATA and STOP.
- DIV=1: every state lasts one cycle. Back-to-back frames are then WIDTH+2 cycles apart.
- Outputs sout, frame, busy, done are registered (glitch-free); load_ready may be decoded from state.
- Counter widths: clog2(DIV) and clog2(WIDTH+1), with a minimum of 1 bit.

Test Plan:
- Reset, WIDTH=4, DIV=4: rst_n=0 -> sout=1, busy=0, load_ready=1, frame=0, done=0. Hold 10 idle cycles after release -> outputs unchanged.
- LSB-first: din=4'b1011, msb_first=0, one-cycle load_valid -> sout = 0,1,1,0,1,1, each held 4 cycles (24 cycles total). frame high for cycles 5-20. done pulses on cycle 24.
- MSB-first: din=4'b1011, msb_first=1 -> data bits on sout = 1,0,1,1. din changed to 4'b0000 one cycle after acceptance -> transmitted bits unaffected.
- Back-to-back: load_valid held high with din=4'hA then 4'h5. The second word is accepted on the final STOP cycle of the first frame -> start bit follows with no idle cycle. load_valid asserted mid-frame is not accepted (load_ready=0).
- Reset mid-frame: assert rst_n=0 during the second data bit -> sout=1 and busy=0 immediately, without waiting for an edge. The next word after release transmits a correct full frame.
- DIV=1, WIDTH=8: din=8'hC3, LSB-first -> sout = 0,1,1,0,0,0,0,1,1,1 on 10 consecutive cycles; done on cycle 10.
